// File: rtl/hazard_forwarding_unit.sv
// Pipeline hazard controller: load-use stall, redirect flush and EX operand
// forwarding selects, driven from a shadow copy of the EX/MEM/WB destinations.
module hazard_forwarding_unit #(
  parameter int unsigned REG_BITS = 5,
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ID_valid,
  input  logic [REG_BITS-1:0] ID_rs1,
  input  logic [REG_BITS-1:0] ID_rs2,
  input  logic                ID_rs1_used,
  input  logic                ID_rs2_used,
  input  logic [REG_BITS-1:0] ID_rd,
  input  logic                ID_RF_Enable,
  input  logic                ID_Load_Instr,
  input  logic                EX_redirect,
  output logic                cu_mux_sel,
  output logic                PC_LE,
  output logic                IF_ID_LE,
  output logic                IF_ID_flush,
  output logic [1:0]          fwd_sel_A,
  output logic [1:0]          fwd_sel_B,
  output logic [CNT_BITS-1:0] stall_count
);

  typedef struct packed {
    logic                v;
    logic [REG_BITS-1:0] rd;
    logic                wr;
    logic                ld;
  } shadow_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  shadow_t s_ex, s_mem, s_wb;
  shadow_t id_entry, s_ex_next;
  logic    hazard;
  logic    count_stall;
  logic [1:0] fwd_a_next, fwd_b_next;

  function automatic logic match(input shadow_t e, input logic [REG_BITS-1:0] r);
    return e.v && e.wr && (e.rd == r) && (r != '0);
  endfunction

  // Youngest producer wins: EX before MEM before WB.
  function automatic logic [1:0] pick_fwd(input logic [REG_BITS-1:0] r);
    if (match(s_ex, r))       return SEL_EX;
    else if (match(s_mem, r)) return SEL_MEM;
    else if (match(s_wb, r))  return SEL_WB;
    else                      return SEL_RF;
  endfunction

  always_comb begin
    id_entry.v  = ID_valid;
    id_entry.rd = ID_rd;
    id_entry.wr = ID_RF_Enable && (ID_rd != '0);
    id_entry.ld = ID_Load_Instr;
  end

  assign hazard = ID_valid && s_ex.ld &&
                  ((ID_rs1_used && match(s_ex, ID_rs1)) ||
                   (ID_rs2_used && match(s_ex, ID_rs2)));

  // Redirect outranks the load-use stall; both insert a bubble into EX.
  always_comb begin
    cu_mux_sel  = 1'b0;
    PC_LE       = 1'b1;
    IF_ID_LE    = 1'b1;
    IF_ID_flush = 1'b0;
    count_stall = 1'b0;
    s_ex_next   = id_entry;
    fwd_a_next  = SEL_RF;
    fwd_b_next  = SEL_RF;
    if (EX_redirect) begin
      IF_ID_flush = 1'b1;
      cu_mux_sel  = 1'b1;
      s_ex_next   = '0;
    end else if (hazard) begin
      cu_mux_sel  = 1'b1;
      PC_LE       = 1'b0;
      IF_ID_LE    = 1'b0;
      count_stall = 1'b1;
      s_ex_next   = '0;
    end else if (ID_valid) begin
      if (ID_rs1_used) fwd_a_next = pick_fwd(ID_rs1);
      if (ID_rs2_used) fwd_b_next = pick_fwd(ID_rs2);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_ex        <= '0;
      s_mem       <= '0;
      s_wb        <= '0;
      fwd_sel_A   <= SEL_RF;
      fwd_sel_B   <= SEL_RF;
      stall_count <= '0;
    end else begin
      s_wb      <= s_mem;
      s_mem     <= s_ex;
      s_ex      <= s_ex_next;
      fwd_sel_A <= fwd_a_next;
      fwd_sel_B <= fwd_b_next;
      if (count_stall && (stall_count != '1))
        stall_count <= stall_count + CNT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// Table-driven bench for hazard_forwarding_unit; registered outputs are
// checked through a scoreboard queue one edge after each vector is driven.
module tb_hazard_forwarding_unit;

  localparam int unsigned RB = 5;
  localparam int unsigned CB = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ID_valid = 1'b0;
  logic [RB-1:0] ID_rs1 = '0, ID_rs2 = '0, ID_rd = '0;
  logic          ID_rs1_used = 1'b0, ID_rs2_used = 1'b0;
  logic          ID_RF_Enable = 1'b0, ID_Load_Instr = 1'b0, EX_redirect = 1'b0;
  logic          cu_mux_sel, PC_LE, IF_ID_LE, IF_ID_flush;
  logic [1:0]    fwd_sel_A, fwd_sel_B;
  logic [CB-1:0] stall_count;

  hazard_forwarding_unit #(.REG_BITS(RB), .CNT_BITS(CB)) dut (
    .clk(clk), .reset_n(reset_n),
    .ID_valid(ID_valid), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_rs1_used(ID_rs1_used), .ID_rs2_used(ID_rs2_used),
    .ID_rd(ID_rd), .ID_RF_Enable(ID_RF_Enable), .ID_Load_Instr(ID_Load_Instr),
    .EX_redirect(EX_redirect),
    .cu_mux_sel(cu_mux_sel), .PC_LE(PC_LE), .IF_ID_LE(IF_ID_LE),
    .IF_ID_flush(IF_ID_flush), .fwd_sel_A(fwd_sel_A), .fwd_sel_B(fwd_sel_B),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic          vld;
    logic [RB-1:0] rs1, rs2, rd;
    logic          u1, u2, rfe, ld, redir;
    logic          cu, le, fl;
    logic [1:0]    fa, fb;
    logic [CB-1:0] cnt;
  } vec_t;

  typedef struct {
    string         name;
    logic [1:0]    fa, fb;
    logic [CB-1:0] cnt;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input string nm, input bit vld, input int r1, input bit u1,
                              input int r2, input bit u2, input int rd, input bit rfe,
                              input bit ld, input bit redir, input bit cu, input bit le,
                              input bit fl, input int fa, input int fb, input int cnt);
    vec_t v;
    v.name = nm; v.vld = vld; v.rs1 = RB'(r1); v.u1 = u1; v.rs2 = RB'(r2); v.u2 = u2;
    v.rd = RB'(rd); v.rfe = rfe; v.ld = ld; v.redir = redir;
    v.cu = cu; v.le = le; v.fl = fl; v.fa = 2'(fa); v.fb = 2'(fb); v.cnt = CB'(cnt);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    ID_valid = v.vld; ID_rs1 = v.rs1; ID_rs1_used = v.u1; ID_rs2 = v.rs2;
    ID_rs2_used = v.u2; ID_rd = v.rd; ID_RF_Enable = v.rfe;
    ID_Load_Instr = v.ld; EX_redirect = v.redir;
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    exp_t got;
    @(negedge clk);
    drive(v);
    #1;
    chk({v.name, ".cu_mux_sel"}, 16'(cu_mux_sel), 16'(v.cu));
    chk({v.name, ".PC_LE"}, 16'(PC_LE), 16'(v.le));
    chk({v.name, ".IF_ID_LE"}, 16'(IF_ID_LE), 16'(v.le));
    chk({v.name, ".IF_ID_flush"}, 16'(IF_ID_flush), 16'(v.fl));
    e.name = v.name; e.fa = v.fa; e.fb = v.fb; e.cnt = v.cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({got.name, ".fwd_sel_A"}, 16'(fwd_sel_A), 16'(got.fa));
    chk({got.name, ".fwd_sel_B"}, 16'(fwd_sel_B), 16'(got.fb));
    chk({got.name, ".stall_count"}, 16'(stall_count), 16'(got.cnt));
  endtask

  initial begin
    // name vld rs1 u1 rs2 u2 rd rfe ld redir | cu le fl fa fb cnt
    tbl.push_back(mk("nop0",       0, 0,0, 0,0,  0,0,0,0, 0,1,0, 0,0,0));
    tbl.push_back(mk("nop1",       0, 0,0, 0,0,  0,0,0,0, 0,1,0, 0,0,0));
    tbl.push_back(mk("nop2",       0, 0,0, 0,0,  0,0,0,0, 0,1,0, 0,0,0));
    tbl.push_back(mk("add5",       1, 1,1, 2,1,  5,1,0,0, 0,1,0, 0,0,0));
    tbl.push_back(mk("sub_d1",     1, 5,1, 6,1,  8,1,0,0, 0,1,0, 1,0,0));
    tbl.push_back(mk("add9",       1, 1,1, 2,1,  9,1,0,0, 0,1,0, 0,0,0));
    tbl.push_back(mk("unrel10",    1, 3,1, 4,1, 10,1,0,0, 0,1,0, 0,0,0));
    tbl.push_back(mk("use_d2",     1, 9,1, 0,0, 11,1,0,0, 0,1,0, 2,0,0));
    tbl.push_back(mk("add12",      1, 1,1, 2,1, 12,1,0,0, 0,1,0, 0,0,0));
    tbl.push_back(mk("unrel13",    1, 3,1, 4,1, 13,1,0,0, 0,1,0, 0,0,0));
    tbl.push_back(mk("unrel14",    1, 3,1, 4,1, 14,1,0,0, 0,1,0, 0,0,0));
    tbl.push_back(mk("use_d3",     1, 1,1,12,1, 15,1,0,0, 0,1,0, 0,3,0));
    tbl.push_back(mk("x3a",        1, 1,1, 2,1,  3,1,0,0, 0,1,0, 0,0,0));
    tbl.push_back(mk("x3b",        1, 1,1, 2,1,  3,1,0,0, 0,1,0, 0,0,0));
    tbl.push_back(mk("x3c",        1, 1,1, 2,1,  3,1,0,0, 0,1,0, 0,0,0));
    tbl.push_back(mk("use_x3",     1, 3,1, 3,1, 16,1,0,0, 0,1,0, 1,1,0));
    tbl.push_back(mk("x0a",        1, 1,1, 2,1,  0,1,0,0, 0,1,0, 0,0,0));
    tbl.push_back(mk("x0b",        1, 1,1, 2,1,  0,1,0,0, 0,1,0, 0,0,0));
    tbl.push_back(mk("x0ld",       1, 1,1, 2,1,  0,1,1,0, 0,1,0, 0,0,0));
    tbl.push_back(mk("use_x0",     1, 0,1, 0,1, 17,1,0,0, 0,1,0, 0,0,0));
    tbl.push_back(mk("lw7",        1, 1,1, 0,0,  7,1,1,0, 0,1,0, 0,0,0));
    tbl.push_back(mk("lu_stall",   1, 2,1, 7,1, 18,1,0,0, 1,0,0, 0,0,1));
    tbl.push_back(mk("lu_go",      1, 2,1, 7,1, 18,1,0,0, 0,1,0, 0,2,1));
    tbl.push_back(mk("lw4",        1, 1,1, 0,0,  4,1,1,0, 0,1,0, 0,0,1));
    tbl.push_back(mk("redir_haz",  1, 4,1, 2,1, 19,1,0,1, 1,1,1, 0,0,1));
    tbl.push_back(mk("post_redir", 1, 4,1, 0,0, 20,1,0,0, 0,1,0, 2,0,1));
    tbl.push_back(mk("lw21",       1, 1,1, 0,0, 21,1,1,0, 0,1,0, 0,0,1));
    tbl.push_back(mk("lw22_stall", 1,21,1, 0,0, 22,1,1,0, 1,0,0, 0,0,2));
    tbl.push_back(mk("lw22_go",    1,21,1, 0,0, 22,1,1,0, 0,1,0, 2,0,2));
    tbl.push_back(mk("add_stall",  1,22,1,21,1, 23,1,0,0, 1,0,0, 0,0,3));
    tbl.push_back(mk("add_go",     1,22,1,21,1, 23,1,0,0, 0,1,0, 2,0,3));
    tbl.push_back(mk("lw24",       1, 1,1, 0,0, 24,1,1,0, 0,1,0, 0,0,3));
    tbl.push_back(mk("sat_stall",  1,24,1, 0,0, 25,1,0,0, 1,0,0, 0,0,3));
    tbl.push_back(mk("sat_go",     1,24,1, 0,0, 25,1,0,0, 0,1,0, 2,0,3));
    tbl.push_back(mk("invalid_id", 0,25,1, 0,0, 26,1,0,0, 0,1,0, 0,0,3));
    tbl.push_back(mk("unused_rs",  1,25,0, 0,0, 27,1,0,0, 0,1,0, 0,0,3));
    tbl.push_back(mk("lw26",       1, 1,1, 0,0, 26,1,1,0, 0,1,0, 0,0,3));

    // Reset held for two cycles with random ID inputs (no redirect).
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      ID_valid = 1'($urandom); ID_rs1 = RB'($urandom); ID_rs2 = RB'($urandom);
      ID_rs1_used = 1'($urandom); ID_rs2_used = 1'($urandom); ID_rd = RB'($urandom);
      ID_RF_Enable = 1'($urandom); ID_Load_Instr = 1'($urandom); EX_redirect = 1'b0;
      #1;
      chk("rst.cu_mux_sel", 16'(cu_mux_sel), 16'd0);
      chk("rst.PC_LE", 16'(PC_LE), 16'd1);
      chk("rst.IF_ID_LE", 16'(IF_ID_LE), 16'd1);
      chk("rst.IF_ID_flush", 16'(IF_ID_flush), 16'd0);
      chk("rst.fwd_sel_A", 16'(fwd_sel_A), 16'd0);
      chk("rst.fwd_sel_B", 16'(fwd_sel_B), 16'd0);
      chk("rst.stall_count", 16'(stall_count), 16'd0);
    end
    drive(tbl[0]);
    reset_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    // Reset asserted in the middle of a load-use stall.
    @(negedge clk);
    ID_valid = 1'b1; ID_rs1 = RB'(26); ID_rs1_used = 1'b1; ID_rs2_used = 1'b0;
    ID_rd = RB'(28); ID_RF_Enable = 1'b1; ID_Load_Instr = 1'b0; EX_redirect = 1'b0;
    #1;
    chk("mid.stall_cu", 16'(cu_mux_sel), 16'd1);
    chk("mid.stall_PC_LE", 16'(PC_LE), 16'd0);
    reset_n = 1'b0;
    #1;
    chk("mid.rst_cu", 16'(cu_mux_sel), 16'd0);
    chk("mid.rst_PC_LE", 16'(PC_LE), 16'd1);
    chk("mid.rst_IF_ID_LE", 16'(IF_ID_LE), 16'd1);
    chk("mid.rst_count", 16'(stall_count), 16'd0);
    chk("mid.rst_fwd_A", 16'(fwd_sel_A), 16'd0);
    @(posedge clk);
    #1;
    chk("mid.rst_count_hold", 16'(stall_count), 16'd0);
    chk("mid.rst_cu_hold", 16'(cu_mux_sel), 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    ID_valid = 1'b0;

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
